// File: rtl/etm_pkg.sv
// Shared types and helpers for the etm_mac_acc multiply-accumulate back end.
package etm_pkg;

  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } etm_mac_state_t;

  // A programmed length of zero still means one product per vector.
  function automatic int unsigned len_norm(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/etm_sat_add.sv
// Unsigned accumulator adder with a zero-extended product addend.
// ETM_MAC_SAT_EN selects a clamp-to-all-ones on carry out; otherwise the sum wraps.
import etm_pkg::*;

module etm_sat_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sat_o
);

`ifdef ETM_MAC_SAT_EN
  logic [ACC_W:0] sum_w;

  assign sum_w = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
  assign sat_o = sum_w[ACC_W];
  assign sum_o = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign sum_o = acc_i + ACC_W'(prod_i);
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/etm_mac_acc.sv
// Streaming dot-product accumulator behind the approximate multiplier; saturation via ETM_MAC_SAT_EN.
// States: IDLE wait for first beat | ACC summing remaining beats | HOLD result presented.
import etm_pkg::*;

module etm_mac_acc #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_exact,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LEN_W:0]    out_exact_cnt,
  output logic              out_sat
);

  etm_mac_state_t   state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   exact_q, exact_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] add_base;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;

  // The first beat of a vector starts from zero rather than the cleared accumulator.
  assign add_base = (state_q == ACC) ? acc_q : '0;

  etm_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc_i  (add_base),
    .prod_i (in_prod),
    .sum_o  (add_sum),
    .sat_o  (add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      exact_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      exact_q <= exact_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    exact_d = exact_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          len_d   = LEN_W'(len_norm(32'(cfg_len)));
          acc_d   = add_sum;
          cnt_d   = LEN_W'(1);
          exact_d = (LEN_W+1)'(in_exact);
          sat_d   = 1'b0;
          state_d = (len_d == LEN_W'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + LEN_W'(1);
          exact_d = exact_q + (LEN_W+1)'(in_exact);
          sat_d   = sat_q | add_sat;
          if (cnt_d == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          exact_d = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q != HOLD);
  assign out_valid     = (state_q == HOLD);
  assign out_acc       = out_valid ? acc_q : '0;
  assign out_exact_cnt = out_valid ? exact_q : '0;
  assign out_sat       = out_valid & sat_q;

endmodule

// File: doc/etm_mac_acc.md
# etm_mac_acc

Streaming multiply-accumulate back end that sits directly downstream of the 16x16 approximate multiplier (mul16_evo218 family). It consumes one 32-bit product per handshake, sums a programmable number of products into a wide accumulator, and presents the finished dot product with range and exact-path statistics under a valid/ready handshake. The block is the first sequential stage after the combinational multiplier. It turns the multiplier into a usable dot-product engine for error-tolerant workloads.

## Interface
- ACC_W, 40, accumulator and result width in bits; must be at least 32.
- LEN_W, 8, width of the vector-length field and the beat counter.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; asynchronous and active-high; clears all state.
- cfg_len  input  LEN_W  number of products per vector; 0 is treated as 1.
- in_valid  input  1  in_prod and in_exact are valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_prod  input  32  unsigned product from the multiplier.
- in_exact  input  1  1 when the product came from the exact path (a<=255 or b<=255).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  final sum.
- out_exact_cnt  output  LEN_W+1  number of exact-path beats in the vector.
- out_sat  output  1  accumulator saturated during the vector.

## Operation
- States: IDLE, ACC, HOLD. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On the first beat, cfg_len is latched into len_q (0 is stored as 1), acc=in_prod, cnt=1, and exact_cnt=in_exact.
  - If len_q==1, the block goes to HOLD. Otherwise it goes to ACC.
- ACC:
  - in_ready=1.
  - Each accepted beat performs acc=acc+in_prod, cnt+=1, and exact_cnt+=in_exact.
  - When the updated cnt equals len_q, the block goes to HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_acc, out_exact_cnt and out_sat are the registered final values and stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, the block goes to IDLE and clears acc, cnt, exact_cnt and the saturation flag.
- cfg_len is sampled only on the first beat. Changes mid-vector are ignored.
- Arithmetic:
  - Unsigned. in_prod is zero-extended to ACC_W+1 before the add.
  - With ETM_MAC_SAT_EN, a carry out of ACC_W bits clamps acc to all-ones and sets sat_q. sat_q is sticky until the vector completes.
- Idle beats (in_valid=0) leave all state unchanged in every state.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_acc=0, out_exact_cnt=0, out_sat=0.
  - State is IDLE.
- Throughput is one beat per cycle in IDLE and ACC.
- Latency: out_valid rises on the cycle after the clock edge that accepts the len_q-th beat.
- Back-to-back vectors:
  - A new first beat can be accepted in the cycle after the output handshake.
  - The minimum gap between vectors is therefore one bubble cycle per result.
- in_ready is a registered function of state only. It does not depend combinationally on out_ready.
- rst asserted mid-vector or in HOLD:
  - The block aborts immediately.
  - out_valid drops asynchronously.
  - No partial result is ever presented.
- cnt counts up to 2^LEN_W-1. len_q never exceeds that, so the counter cannot wrap.

## Configuration
- ETM_MAC_SAT_EN, when defined:
  - Saturating accumulate with the sticky out_sat flag.
  - The add path is ACC_W+1 bits wide with a clamp.
- ETM_MAC_SAT_EN, when undefined:
  - Modulo-2^ACC_W wrap-around accumulate.
  - out_sat is tied to 0 and the clamp logic is absent.

## Structure
- Package etm_pkg:
  - state enum etm_mac_state_t (IDLE, ACC, HOLD).
  - PROD_W=32 constant.
  - helper function len_norm(len) that maps 0 to 1.
- One sub-module, etm_sat_add:
  - ACC_W-wide unsigned accumulator adder taking a zero-extended 32-bit addend.
  - Its clamp is selected by ETM_MAC_SAT_EN.
  - The FSM, counters and output registers live in etm_mac_acc.

## Test plan
- Reset with rst pulsed high mid-cycle: all outputs at reset values immediately; in_ready=1 after release.
- cfg_len=4, products 100, 200, 300, 400 with in_exact=1,0,1,1 sent back-to-back:
  - out_valid rises one cycle after the 4th beat.
  - out_acc=1000, out_exact_cnt=3, out_sat=0.
- cfg_len=0, single product 0xFFFE0001: out_acc=0xFFFE0001 and out_exact_cnt=0; vector length 1 is confirmed.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD.
  - Outputs stay stable and in_ready=0.
  - Extra in_valid beats are not consumed.
  - Release out_ready: one bubble cycle, then the next vector is accepted.
- ACC_W=33, cfg_len=3, three products of 0xFFFFFFFF:
  - With ETM_MAC_SAT_EN: out_acc=0x1FFFFFFFF, out_sat=1.
  - Without it: out_acc=0x0FFFFFFFD, out_sat=0.
- Start a vector with cfg_len=3, change cfg_len to 1 after beat 1, and insert in_valid gaps: result still completes after 3 accepted beats with the correct sum.
